mcpu_mem_word_adapter: RTL and testbench
========================================

Name: mcpu_mem_word_adapter

Overview:
- Client-side front end for one memory-arbiter port.
- Accepts 32-bit word read/write requests from a simple valid/ready master, such as a CPU load/store unit or a DMA engine.
- Converts each request into a 256-bit line request on the arbiter client interface.
- Tracks outstanding reads and returns the selected 32-bit word from each returned line, in order.
- Sits directly upstream of the memory arbiter; one instance is built per arbiter client slot.

Parameters:
- MAX_RD, 4, maximum outstanding reads (tracker FIFO depth); power of two, 2..16.
- MAX_RD_BITS, 2, log2(MAX_RD).

Ports:
- clkrst_mem_clk  in  1  memory clock; all state on its rising edge.
- clkrst_mem_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  master request valid.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  30  word address [31:2].
- req_wdata  in  32  write data.
- req_be  in  4  write byte enables; ignored for reads.
- resp_valid  out  1  read data valid, one-cycle pulse.
- resp_rdata  out  32  read data word.
- cli2arb_valid  out  1  line request valid to arbiter.
- cli2arb_opcode  out  3  LTC_OPC_READ or LTC_OPC_WRITE.
- cli2arb_addr  out  27  line address [31:5].
- cli2arb_wdata  out  256  write line.
- cli2arb_wbe  out  32  line byte enables.
- cli2arb_stall  in  1  arbiter not accepting; the request is accepted on a cycle where valid && !stall.
- cli2arb_rdata  in  256  returned line.
- cli2arb_rvalid  in  1  returned line valid; returns are in issue order.
- err_underflow  out  1  sticky: rvalid arrived while the tracker was empty.

Behaviour:
- Reset (async): request register empty, tracker empty, resp_valid=0, resp_rdata=0, err_underflow=0, cli2arb_valid=0. All in-flight reads are discarded.
- Request register, one entry:
  - Holds the request's opcode, addr[31:5], word offset addr[4:2], wdata and be.
  - Registered on acceptance; drives cli2arb_* directly from flops.
  - cli2arb_valid = register full.
- Issue:
  - Issue occurs on a cycle where cli2arb_valid && !cli2arb_stall; the register empties unless refilled the same cycle.
  - While stalled, every cli2arb_* output stays stable.
- req_ready = (!full || issue) && (req_we || rd_cnt_next < MAX_RD).
  - rd_cnt counts reads held in the register plus reads in flight.
  - rd_cnt_next is the count after this cycle's return (if any) and before this acceptance.
  - Writes never block on the tracker.
  - Back-to-back acceptance is allowed: with no stall, throughput is one request per clock.
- Line formatting:
  - wdata = req_wdata replicated 8 times.
  - wbe = req_be << (4*offset) for writes; 32'h0 for reads.
  - Opcode for reads is LTC_OPC_READ; for writes it is LTC_OPC_WRITE.
- Tracker (FIFO, width 3, depth MAX_RD):
  - Push the word offset on issue of a read.
  - Pop on cli2arb_rvalid.
  - Simultaneous push and pop are legal, including when the tracker is full or empty-with-push.
- rd_cnt update: increments on acceptance of a read; decrements on rvalid. Simultaneous increment and decrement nets to zero. Must never exceed MAX_RD.
- Response:
  - resp_valid is registered: high the cycle after cli2arb_rvalid.
  - resp_rdata = cli2arb_rdata[32*off +: 32], where off is the tracker head.
  - resp_rdata holds its last value otherwise.
  - Total read latency = arbiter return latency + 1.
- Writes are posted: no response.
- Read/write ordering: preserved by the arbiter's single in-order path; there is no bypass.
- Underflow: rvalid with tracker empty sets err_underflow (cleared only by reset), does not pulse resp_valid, and the tracker is not popped.
- Wrap-around: the tracker pointers are MAX_RD_BITS wide and wrap naturally.

Decomposition:
- Shared package: LTC opcode constants (LTC_OPC_READ, LTC_OPC_WRITE, LTC_OPC_READTHROUGH), line/word width constants (256, 32, 8 words/line).
- One sub-module: the existing generic FIFO (instance rd_trk, DEPTH=MAX_RD, WIDTH=3); reuse it, do not re-implement.
- Lane shift/replication stays inline.

Test Plan:
- Single read: addr=30'h0000_0005 (offset 5), no stall. Expect:
  - cli2arb_addr = 27'h0, opcode = READ, wbe = 0.
  - Return rdata with word i = 32'hA000_000i.
  - resp_rdata = 32'hA000_0005 one cycle after rvalid.
- Write lane: req_we=1, addr offset 3, be=4'b0110, wdata=32'hDEADBEEF. Expect:
  - wbe = 32'h0000_6000, wdata replicated in all 8 lanes.
  - No resp_valid.
- Stall hold: stall high 5 cycles with read pending. Expect:
  - cli2arb_* stable.
  - req_ready=0 while the register is full.
  - Issue on the first unstalled cycle; the next request is accepted that same cycle.
- Tracker full: 4 reads (offsets 0,1,2,3) issued with no returns; 5th read. Expect:
  - req_ready=0 on the 5th read; a write is still accepted once the register frees.
  - rvalid plus a new read request in the same cycle → read accepted.
  - Responses return offsets 0,1,2,3 in order.
- Underflow: rvalid with nothing outstanding. Expect:
  - err_underflow=1 and stays set.
  - resp_valid stays 0.
- Reset mid-operation: 2 reads in flight, assert rst_n low. Expect:
  - All outputs at reset values immediately (async).
  - rd_cnt=0 after release; a fresh read completes normally.

Source files
------------

// File: rtl/mcpu_mem_word_adapter_pkg.sv
// Shared constants for the memory word adapter: LTC opcodes and line/word geometry.
// Also provides the helper that places word byte enables into line byte enables.
package mcpu_mem_word_adapter_pkg;

  localparam int LINE_W         = 256;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFF_W          = 3;
  localparam int WORD_ADDR_W    = 30;
  localparam int LINE_ADDR_W    = 27;
  localparam int LINE_BE_W      = 32;
  localparam int WORD_BE_W      = 4;

  typedef enum logic [2:0] {
    LTC_OPC_READ        = 3'd0,
    LTC_OPC_WRITE       = 3'd1,
    LTC_OPC_READTHROUGH = 3'd2
  } ltc_opc_e;

  // Each word occupies four byte lanes of the line, so the shift is 4*offset.
  function automatic logic [LINE_BE_W-1:0] line_wbe(input logic [WORD_BE_W-1:0] be,
                                                    input logic [OFF_W-1:0] off);
    logic [LINE_BE_W-1:0] wide;
    wide = {{(LINE_BE_W-WORD_BE_W){1'b0}}, be};
    return wide << {off, 2'b00};
  endfunction

endpackage

// File: rtl/mcpu_mem_word_adapter_fifo.sv
// Generic synchronous FIFO with async active-low reset; DEPTH must be a power of two.
// Pop on empty is ignored; push while full is only taken when a pop frees the slot.
module mcpu_mem_word_adapter_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/mcpu_mem_word_adapter.sv
// Word-to-line front end for one memory-arbiter client port: one-entry request
// register feeding the arbiter, plus an offset tracker that picks read words from returned lines.
module mcpu_mem_word_adapter
  import mcpu_mem_word_adapter_pkg::*;
#(
  parameter int MAX_RD      = 4,
  parameter int MAX_RD_BITS = 2
) (
  input  logic                   clkrst_mem_clk,
  input  logic                   clkrst_mem_rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WORD_ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0]      req_wdata,
  input  logic [WORD_BE_W-1:0]   req_be,
  output logic                   resp_valid,
  output logic [WORD_W-1:0]      resp_rdata,
  output logic                   cli2arb_valid,
  output logic [2:0]             cli2arb_opcode,
  output logic [LINE_ADDR_W-1:0] cli2arb_addr,
  output logic [LINE_W-1:0]      cli2arb_wdata,
  output logic [LINE_BE_W-1:0]   cli2arb_wbe,
  input  logic                   cli2arb_stall,
  input  logic [LINE_W-1:0]      cli2arb_rdata,
  input  logic                   cli2arb_rvalid,
  output logic                   err_underflow
);

  localparam int CNT_W = MAX_RD_BITS + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RD);

  ltc_opc_e               req_opc;
  logic                   req_full;
  logic [LINE_ADDR_W-1:0] req_line_addr;
  logic [OFF_W-1:0]       req_off;
  logic [WORD_W-1:0]      req_wdata_q;
  logic [LINE_BE_W-1:0]   req_wbe_q;

  logic [CNT_W-1:0]       rd_cnt;
  logic [CNT_W-1:0]       rd_cnt_next;
  logic                   issue;
  logic                   accept;
  logic                   accept_rd;

  logic                   trk_push;
  logic                   trk_pop;
  logic [OFF_W-1:0]       trk_head;
  logic                   trk_full;
  logic                   trk_empty;

  // A return with nothing tracked is an underflow and must not disturb the count.
  assign trk_pop     = cli2arb_rvalid && !trk_empty;
  assign issue       = req_full && !cli2arb_stall;
  assign rd_cnt_next = rd_cnt - {{MAX_RD_BITS{1'b0}}, trk_pop};
  assign req_ready   = (!req_full || issue) && (req_we || (rd_cnt_next < MAX_CNT));
  assign accept      = req_valid && req_ready;
  assign accept_rd   = accept && !req_we;
  assign trk_push    = issue && (req_opc == LTC_OPC_READ);

  always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
    if (!clkrst_mem_rst_n) begin
      req_full      <= 1'b0;
      req_opc       <= LTC_OPC_READ;
      req_line_addr <= '0;
      req_off       <= '0;
      req_wdata_q   <= '0;
      req_wbe_q     <= '0;
    end else begin
      req_full <= accept || (req_full && !issue);
      if (accept) begin
        req_opc       <= req_we ? LTC_OPC_WRITE : LTC_OPC_READ;
        req_line_addr <= req_addr[WORD_ADDR_W-1:OFF_W];
        req_off       <= req_addr[OFF_W-1:0];
        req_wdata_q   <= req_wdata;
        req_wbe_q     <= req_we ? line_wbe(req_be, req_addr[OFF_W-1:0]) : '0;
      end
    end
  end

  // rd_cnt covers the read sitting in the register as well as reads in flight.
  always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
    if (!clkrst_mem_rst_n) begin
      rd_cnt <= '0;
    end else begin
      rd_cnt <= rd_cnt_next + {{MAX_RD_BITS{1'b0}}, accept_rd};
    end
  end

  mcpu_mem_word_adapter_fifo #(
    .DEPTH (MAX_RD),
    .WIDTH (OFF_W)
  ) rd_trk (
    .clk       (clkrst_mem_clk),
    .rst_n     (clkrst_mem_rst_n),
    .push      (trk_push),
    .push_data (req_off),
    .pop       (trk_pop),
    .pop_data  (trk_head),
    .full      (trk_full),
    .empty     (trk_empty)
  );

  always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
    if (!clkrst_mem_rst_n) begin
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      err_underflow <= 1'b0;
    end else begin
      resp_valid    <= trk_pop;
      err_underflow <= err_underflow || (cli2arb_rvalid && trk_empty);
      if (trk_pop) resp_rdata <= cli2arb_rdata[WORD_W*trk_head +: WORD_W];
    end
  end

  assign cli2arb_valid  = req_full;
  assign cli2arb_opcode = req_opc;
  assign cli2arb_addr   = req_line_addr;
  assign cli2arb_wdata  = {WORDS_PER_LINE{req_wdata_q}};
  assign cli2arb_wbe    = req_wbe_q;

  // The count bound keeps the tracker from overflowing.
  always_ff @(posedge clkrst_mem_clk) begin
    if (clkrst_mem_rst_n) begin
      assert (!(trk_push && trk_full && !trk_pop));
      assert (rd_cnt <= MAX_CNT);
    end
  end

endmodule

// File: tb/tb_mcpu_mem_word_adapter.sv
// Directed bench for mcpu_mem_word_adapter; read results are scored through an
// expected-word queue filled when each read request is driven.
module tb_mcpu_mem_word_adapter;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [29:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_be;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         cli2arb_valid;
  logic [2:0]   cli2arb_opcode;
  logic [26:0]  cli2arb_addr;
  logic [255:0] cli2arb_wdata;
  logic [31:0]  cli2arb_wbe;
  logic         cli2arb_stall;
  logic [255:0] cli2arb_rdata;
  logic         cli2arb_rvalid;
  logic         err_underflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q [$];

  localparam logic [2:0] OPC_RD = 3'd0;
  localparam logic [2:0] OPC_WR = 3'd1;

  mcpu_mem_word_adapter #(.MAX_RD(4), .MAX_RD_BITS(2)) dut (
    .clkrst_mem_clk   (clk),
    .clkrst_mem_rst_n (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_be           (req_be),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .cli2arb_valid    (cli2arb_valid),
    .cli2arb_opcode   (cli2arb_opcode),
    .cli2arb_addr     (cli2arb_addr),
    .cli2arb_wdata    (cli2arb_wdata),
    .cli2arb_wbe      (cli2arb_wbe),
    .cli2arb_stall    (cli2arb_stall),
    .cli2arb_rdata    (cli2arb_rdata),
    .cli2arb_rvalid   (cli2arb_rvalid),
    .err_underflow    (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [29:0] addr,
                               input logic [31:0] wd, input logic [3:0] be,
                               input logic st, input logic rv, input logic [255:0] rl);
    req_valid      = v;
    req_we         = we;
    req_addr       = addr;
    req_wdata      = wd;
    req_be         = be;
    cli2arb_stall  = st;
    cli2arb_rvalid = rv;
    cli2arb_rdata  = rl;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [255:0] make_line(input int tag);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'hA000_0000 | (32'(tag) << 8) | 32'(i);
    return l;
  endfunction

  function automatic logic [31:0] exp_word(input int tag, input int off);
    return 32'hA000_0000 | (32'(tag) << 8) | 32'(off);
  endfunction

  function automatic logic [29:0] mk_addr(input int line, input int off);
    return (30'(line) << 3) | 30'(off);
  endfunction

  // Every read response is matched against the oldest expected word.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) checkOutput("resp_unexpected", {255'b0, resp_valid}, 256'd0);
      else checkOutput("resp_data", resp_rdata, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    checkOutput("rst_cli_valid", cli2arb_valid, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_rdata", resp_rdata, 0);
    checkOutput("rst_err", err_underflow, 0);
    checkOutput("rst_req_ready", req_ready, 1);
    #10 rst_n = 1'b1;

    $display("[TB] single read");
    tick();
    applyStimulus(1, 0, 30'h0000_0005, 32'h0, 4'hF, 0, 0, '0);
    checkOutput("rd1_ready", req_ready, 1);
    exp_q.push_back(exp_word(0, 5));
    tick();
    idle();
    checkOutput("rd1_cli_valid", cli2arb_valid, 1);
    checkOutput("rd1_cli_addr", cli2arb_addr, 27'h0);
    checkOutput("rd1_cli_opc", cli2arb_opcode, OPC_RD);
    checkOutput("rd1_cli_wbe", cli2arb_wbe, 32'h0);
    tick();
    checkOutput("rd1_issued", cli2arb_valid, 0);
    applyStimulus(0, 0, 30'h0, 32'h0, 4'h0, 0, 1, make_line(0));
    tick();
    idle();
    checkOutput("rd1_resp_valid", resp_valid, 1);
    checkOutput("rd1_resp_rdata", resp_rdata, 32'hA000_0005);
    tick();
    checkOutput("rd1_resp_pulse", resp_valid, 0);

    $display("[TB] write lane");
    applyStimulus(1, 1, mk_addr(2, 3), 32'hDEAD_BEEF, 4'b0110, 0, 0, '0);
    checkOutput("wr_ready", req_ready, 1);
    tick();
    idle();
    checkOutput("wr_cli_valid", cli2arb_valid, 1);
    checkOutput("wr_cli_opc", cli2arb_opcode, OPC_WR);
    checkOutput("wr_cli_addr", cli2arb_addr, 27'h2);
    checkOutput("wr_cli_wbe", cli2arb_wbe, 32'h0000_6000);
    checkOutput("wr_cli_wdata", cli2arb_wdata, {8{32'hDEAD_BEEF}});
    tick();
    tick();
    checkOutput("wr_no_resp", resp_valid, 0);

    $display("[TB] stall hold");
    applyStimulus(1, 0, mk_addr(9, 2), 32'h0, 4'h0, 0, 0, '0);
    exp_q.push_back(exp_word(1, 2));
    tick();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1, 0, mk_addr(10, 1), 32'h0, 4'h0, 1, 0, '0);
      checkOutput("stall_ready", req_ready, 0);
      checkOutput("stall_valid", cli2arb_valid, 1);
      checkOutput("stall_addr", cli2arb_addr, 27'd9);
      checkOutput("stall_opc", cli2arb_opcode, OPC_RD);
      tick();
    end
    applyStimulus(1, 0, mk_addr(10, 1), 32'h0, 4'h0, 0, 0, '0);
    checkOutput("unstall_ready", req_ready, 1);
    exp_q.push_back(exp_word(2, 1));
    tick();
    idle();
    checkOutput("unstall_next_addr", cli2arb_addr, 27'd10);
    tick();
    applyStimulus(0, 0, 30'h0, 32'h0, 4'h0, 0, 1, make_line(1));
    tick();
    applyStimulus(0, 0, 30'h0, 32'h0, 4'h0, 0, 1, make_line(2));
    tick();
    idle();
    checkOutput("stall_last_rdata", resp_rdata, exp_word(2, 1));

    $display("[TB] tracker full");
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, mk_addr(16 + k, k), 32'h0, 4'h0, 0, 0, '0);
      checkOutput("full_fill_ready", req_ready, 1);
      exp_q.push_back(exp_word(3 + k, k));
      tick();
    end
    applyStimulus(1, 0, mk_addr(30, 4), 32'h0, 4'h0, 0, 0, '0);
    checkOutput("full_5th_blocked", req_ready, 0);
    tick();
    applyStimulus(1, 0, mk_addr(30, 4), 32'h0, 4'h0, 0, 0, '0);
    checkOutput("full_5th_still_blocked", req_ready, 0);
    applyStimulus(1, 1, mk_addr(31, 0), 32'h1234_5678, 4'hF, 0, 0, '0);
    checkOutput("full_write_ready", req_ready, 1);
    tick();
    applyStimulus(1, 0, mk_addr(30, 4), 32'h0, 4'h0, 0, 1, make_line(3));
    checkOutput("full_ret_plus_read", req_ready, 1);
    exp_q.push_back(exp_word(7, 4));
    tick();
    idle();
    checkOutput("full_read_loaded", cli2arb_addr, 27'd30);
    tick();
    for (int k = 4; k < 8; k++) begin
      applyStimulus(0, 0, 30'h0, 32'h0, 4'h0, 0, 1, make_line(k));
      tick();
    end
    idle();
    checkOutput("full_last_rdata", resp_rdata, exp_word(7, 4));

    $display("[TB] underflow");
    tick();
    applyStimulus(0, 0, 30'h0, 32'h0, 4'h0, 0, 1, make_line(9));
    tick();
    idle();
    checkOutput("uf_err_set", err_underflow, 1);
    checkOutput("uf_no_resp", resp_valid, 0);
    tick();
    tick();
    checkOutput("uf_err_sticky", err_underflow, 1);

    $display("[TB] reset mid-operation");
    applyStimulus(1, 0, mk_addr(50, 1), 32'h0, 4'h0, 0, 0, '0);
    tick();
    applyStimulus(1, 0, mk_addr(51, 2), 32'h0, 4'h0, 0, 0, '0);
    tick();
    idle();
    checkOutput("mid_cli_valid_before", cli2arb_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_cli_valid", cli2arb_valid, 0);
    checkOutput("mid_rst_resp_valid", resp_valid, 0);
    checkOutput("mid_rst_resp_rdata", resp_rdata, 0);
    checkOutput("mid_rst_err", err_underflow, 0);
    checkOutput("mid_rst_ready", req_ready, 1);
    #3 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, mk_addr(40 + k, 7 - k), 32'h0, 4'h0, 0, 0, '0);
      checkOutput("post_rst_ready", req_ready, 1);
      exp_q.push_back(exp_word(12 + k, 7 - k));
      tick();
    end
    idle();
    tick();
    for (int k = 12; k < 16; k++) begin
      applyStimulus(0, 0, 30'h0, 32'h0, 4'h0, 0, 1, make_line(k));
      tick();
    end
    idle();
    tick();
    tick();
    checkOutput("post_rst_last_rdata", resp_rdata, exp_word(15, 4));
    checkOutput("post_rst_err_clear", err_underflow, 0);
    checkOutput("scoreboard_drained", 256'(exp_q.size()), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
